// File: rtl/retry_buff_ctrl.sv
// retry_buff_ctrl: retry buffer write/replay sequencing with free-entry backpressure.
// A replay re-reads every unacknowledged entry, oldest first, ending just behind wr_ptr.
module retry_buff_ctrl #(
    parameter int         BUFF_DEPTH   = 64,
    parameter int         ADDR_WIDTH   = 6,
    parameter logic [7:0] STALL_THRESH = 8'd1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tx_flit_valid,
    output logic                  o_tx_flit_ready,
    input  logic [7:0]            i_retry_num_free_buff,
    input  logic                  i_replay_req,
    output logic                  o_controller_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]            o_wr_seq,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_replay_active,
    output logic                  o_replay_done
);
    typedef enum logic [1:0] {NORMAL, STALL, REPLAY_LOAD, REPLAY} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [7:0]            seq_cnt;
    logic [ADDR_WIDTH:0]   pend;
    logic [ADDR_WIDTH:0]   load_pend;
    logic                  above;

    assign above = i_retry_num_free_buff > STALL_THRESH;
    // Entries in flight = depth minus free entries, with free clamped to the depth.
    assign load_pend = (int'(i_retry_num_free_buff) >= BUFF_DEPTH) ? '0
                     : (ADDR_WIDTH+1)'(BUFF_DEPTH - int'(i_retry_num_free_buff));
    // Gated by reset so no flit is accepted into a buffer whose pointers are being cleared.
    assign o_tx_flit_ready    = i_rst_n && state == NORMAL && above;
    assign o_controller_wr_en = i_tx_flit_valid && o_tx_flit_ready;
    assign o_wr_addr          = wr_ptr;
    assign o_wr_seq           = seq_cnt;
    assign o_rd_en            = state == REPLAY;
    assign o_rd_addr          = rd_ptr;
    assign o_replay_active    = state == REPLAY_LOAD || state == REPLAY;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= NORMAL;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            seq_cnt       <= '0;
            pend          <= '0;
            o_replay_done <= 1'b0;
        end else begin
            o_replay_done <= 1'b0;
            if (o_controller_wr_en) begin
                wr_ptr  <= wr_ptr + 1'b1;
                seq_cnt <= seq_cnt + 1'b1;
            end
            case (state)
                NORMAL: begin
                    if (i_replay_req) state <= REPLAY_LOAD;
                    else if (!above)  state <= STALL;
                end
                STALL: begin
                    if (i_replay_req) state <= REPLAY_LOAD;
                    else if (above)   state <= NORMAL;
                end
                REPLAY_LOAD: begin
                    pend   <= load_pend;
                    rd_ptr <= wr_ptr - load_pend[ADDR_WIDTH-1:0];
                    if (load_pend == '0) begin
                        o_replay_done <= 1'b1;
                        state         <= above ? NORMAL : STALL;
                    end else begin
                        state <= REPLAY;
                    end
                end
                REPLAY: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    pend   <= pend - 1'b1;
                    if (pend == (ADDR_WIDTH+1)'(1)) begin
                        o_replay_done <= 1'b1;
                        state         <= above ? NORMAL : STALL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retry_buff_ctrl.sv
// tb_retry_buff_ctrl: scenario tasks plus randomized write/stall/replay rounds.
// The model tracks total writes; expected addresses and replay windows follow from that count.
module tb_retry_buff_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       req = 1'b0;
    logic [7:0] free = 8'd64;
    logic       ready, wr_en, rd_en, active, done;
    logic [5:0] wr_addr, rd_addr;
    logic [7:0] wr_seq;
    int checks = 0;
    int failures = 0;
    int wr_total = 0;

    retry_buff_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_flit_valid(valid), .o_tx_flit_ready(ready),
        .i_retry_num_free_buff(free), .i_replay_req(req), .o_controller_wr_en(wr_en),
        .o_wr_addr(wr_addr), .o_wr_seq(wr_seq), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .o_replay_active(active), .o_replay_done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pend_of(input int f);
        return f >= 64 ? 0 : 64 - f;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; valid = 1'b0; req = 1'b0; free = 8'd64;
        tick; tick;
        #1;
        checks++;
        if ({wr_en, rd_en, active, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {wr_en, rd_en, active, done});
        end
        rst_n = 1'b1;
        wr_total = 0;
        #1;
        checks++;
        if ({ready, wr_addr, wr_seq} !== {1'b1, 6'd0, 8'd0}) begin
            failures++;
            $display("FAIL reset_state got ready=%b addr=%0d seq=%0d exp 1/0/0", ready, wr_addr, wr_seq);
        end
    endtask

    task automatic do_writes(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1; free = 8'd64;
            #1;
            checks++;
            if ({wr_en, rd_en, wr_addr, wr_seq} !== {2'b10, 6'(wr_total % 64), 8'(wr_total % 256)}) begin
                failures++;
                $display("FAIL write got en=%b rd=%b addr=%0d seq=%0d exp addr=%0d seq=%0d",
                         wr_en, rd_en, wr_addr, wr_seq, wr_total % 64, wr_total % 256);
            end
            wr_total++;
            tick;
        end
        valid = 1'b0;
    endtask

    task automatic test_stall;
        free = 8'd1; valid = 1'b1;
        #1;
        checks++;
        if ({ready, wr_en} !== 2'b00) begin
            failures++;
            $display("FAIL stall_enter got ready/wr_en=%b exp=00", {ready, wr_en});
        end
        tick;
        checks++;
        if ({ready, wr_en} !== 2'b00) begin
            failures++;
            $display("FAIL stall_hold got ready/wr_en=%b exp=00", {ready, wr_en});
        end
        free = 8'd2;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_exit_same_cycle got ready=%b exp=0", ready);
        end
        tick;
        checks++;
        if ({ready, wr_en, wr_addr} !== {2'b11, 6'(wr_total % 64)}) begin
            failures++;
            $display("FAIL stall_exit got ready=%b wr_en=%b addr=%0d exp 1/1/%0d", ready, wr_en, wr_addr, wr_total % 64);
        end
        wr_total++;
        tick;
        valid = 1'b0;
    endtask

    // Valid is held high through the replay so any write strobe there is caught.
    task automatic run_replay(input int f, input bit extra_req, input bit with_write);
        int p;
        req = 1'b1; valid = with_write; free = with_write ? 8'd64 : 8'(f);
        #1;
        checks++;
        if (wr_en !== with_write) begin
            failures++;
            $display("FAIL replay_req_write got wr_en=%b exp=%b", wr_en, with_write);
        end
        if (with_write) wr_total++;
        tick;
        req = extra_req; valid = 1'b1; free = 8'(f);
        p = pend_of(f);
        #1;
        checks++;
        if ({active, rd_en, done, wr_en} !== 4'b1000) begin
            failures++;
            $display("FAIL replay_load got act/rd/done/wr=%b exp=1000", {active, rd_en, done, wr_en});
        end
        tick;
        for (int k = 0; k < p; k++) begin
            #1;
            checks++;
            if ({active, rd_en, rd_addr, done, wr_en} !== {2'b11, 6'(((wr_total - p + k) % 64 + 64) % 64), 2'b00}) begin
                failures++;
                $display("FAIL replay_read%0d got act=%b rd=%b addr=%0d done=%b wr=%b exp addr=%0d",
                         k, active, rd_en, rd_addr, done, wr_en, ((wr_total - p + k) % 64 + 64) % 64);
            end
            tick;
        end
        req = 1'b0; valid = 1'b0;
        #1;
        checks++;
        if ({active, rd_en, done, ready} !== {3'b001, f > 1}) begin
            failures++;
            $display("FAIL replay_done f=%0d got act/rd/done/ready=%b exp=001%b", f, {active, rd_en, done, ready}, f > 1);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL replay_done_width got done=%b exp=0", done);
        end
    endtask

    task automatic test_reset_mid_replay;
        req = 1'b1; valid = 1'b0; free = 8'd56;
        tick;
        req = 1'b0;
        tick; tick; tick;
        #1;
        checks++;
        if ({rd_en, rd_addr} !== {1'b1, 6'(((wr_total - 8 + 2) % 64 + 64) % 64)}) begin
            failures++;
            $display("FAIL abort_third_read got rd=%b addr=%0d", rd_en, rd_addr);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if ({rd_en, active, done, wr_en} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_outputs got rd/act/done/wr=%b exp=0000", {rd_en, active, done, wr_en});
        end
        rst_n = 1'b1;
        wr_total = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if ({done, active} !== 2'b00) begin
                failures++;
                $display("FAIL abort_no_done cycle%0d got done/act=%b exp=00", i, {done, active});
            end
        end
        do_writes(2);
    endtask

    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            int f;
            do_writes($urandom_range(0, 40));
            f = $urandom_range(0, 4);
            free = 8'(f);
            #1;
            checks++;
            if (ready !== (f > 1)) begin
                failures++;
                $display("FAIL rand_ready f=%0d got=%b exp=%b", f, ready, f > 1);
            end
            tick;
            free = 8'd64;
            tick;
            run_replay($urandom_range(2, 80), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset;
        do_writes(5);
        test_stall;
        do_writes(10 - wr_total);
        run_replay(60, 1'b0, 1'b0);
        do_writes(((2 - wr_total % 64) % 64 + 64) % 64);
        run_replay(59, 1'b0, 1'b0);
        run_replay(64, 1'b0, 1'b0);
        run_replay(70, 1'b0, 1'b0);
        run_replay(61, 1'b1, 1'b0);
        run_replay(62, 1'b0, 1'b1);
        test_reset_mid_replay;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
